// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier bus master: FSM state encoding,
// default parameter values and a small state-classification helper.
package mul_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,  // multiplier held in clear
    ST_IDLE = 3'd1,  // waiting for an operand pair
    ST_WR0  = 3'd2,  // writing operand 0
    ST_WR1  = 3'd3,  // writing operand 1
    ST_RD   = 3'd4,  // reading the product
    ST_OUT  = 3'd5   // presenting the product downstream
  } state_e;

  localparam int SZIN_DEF     = 8;
  localparam int TMO_DEF      = 16;
  localparam int INIT_CYC_DEF = 2;

  // True for the states that drive a multiplier bus phase and are timed.
  function automatic logic is_bus_phase(input state_e s);
    return s inside {ST_WR0, ST_WR1, ST_RD};
  endfunction

endpackage

// File: rtl/mul_bus_master_if.sv
// Multiplier bus between the master and an external multiplier.
//   mul_sel     select to multiplier
//   mul_wrt     1 = operand write, 0 = result read
//   mul_nres    active-low clear
//   mul_addr_b  operand address (0 = operand 0, 1 = operand 1)
//   mul_wdata   operand write data
//   mul_rdata   product returned by the multiplier (2*SZin-1 bits)
//   mul_ready   multiplier has completed the current phase
interface mul_bus_master_if import mul_pkg::*; #(
  parameter int SZin = SZIN_DEF
) ();

  logic              mul_sel;
  logic              mul_wrt;
  logic              mul_nres;
  logic              mul_addr_b;
  logic [SZin-1:0]   mul_wdata;
  logic [2*SZin-2:0] mul_rdata;
  logic              mul_ready;

  modport master (
    output mul_sel, mul_wrt, mul_nres, mul_addr_b, mul_wdata,
    input  mul_rdata, mul_ready
  );

  modport slave (
    input  mul_sel, mul_wrt, mul_nres, mul_addr_b, mul_wdata,
    output mul_rdata, mul_ready
  );

endinterface

// File: rtl/mul_tmo_cnt.sv
// Per-phase timeout counter.
//   clk, res  clock / async active-high reset
//   clr       restart the count (has priority over en)
//   en        a timed bus phase is in progress
//   expired   current cycle is the TMO-th cycle of the phase
// The count equals the number of completed cycles in the phase, so expired
// is raised during the last allowed cycle; a ready in that same cycle still
// wins because the FSM checks ready before expired.
module mul_tmo_cnt #(
  parameter int TMO = 16
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge res) begin
    if (res)                 cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(TMO - 1));

endmodule

// File: rtl/mul_bus_master.sv
// Bus master that feeds operand pairs to an external multiplier and returns
// the product on a valid/ready stream.
//   clk, res                       clock / async active-high reset
//   in_valid, in_ready, in_a, in_b operand pair stream (two's complement)
//   out_valid, out_ready, out_data product stream (2*SZin-1 bits, as delivered)
//   out_err                        one-cycle pulse: a bus phase timed out
//   bus                            multiplier bus (master side)
// Sequence per pair: WR0 (operand 0), WR1 (operand 1), RD (product), OUT.
// A phase that sees no mul_ready within TMO cycles drops the pair and sends
// the multiplier back through a clear sequence.
module mul_bus_master import mul_pkg::*; #(
  parameter int SZin     = SZIN_DEF,
  parameter int TMO      = TMO_DEF,
  parameter int INIT_CYC = INIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SZin-1:0]   in_a,
  input  logic [SZin-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SZin-2:0] out_data,
  output logic              out_err,
  mul_bus_master_if.master  bus
);

  localparam int ICW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  state_e          state;
  logic [ICW-1:0]  icnt;
  logic [SZin-1:0] a_q, b_q;
  logic            in_phase, tmo_clr, expired;

  // Any completed phase restarts the count, so each WR0/WR1/RD entry
  // begins from zero.
  assign in_phase = is_bus_phase(state);
  assign tmo_clr  = !in_phase || bus.mul_ready;

  mul_tmo_cnt #(.TMO(TMO)) u_tmo (
    .clk     (clk),
    .res     (res),
    .clr     (tmo_clr),
    .en      (in_phase),
    .expired (expired)
  );

  // Write data follows the registered operand address, so it only changes
  // at the same edges as the rest of the bus.
  assign bus.mul_wdata = bus.mul_addr_b ? b_q : a_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state          <= ST_INIT;
      icnt           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      out_err        <= 1'b0;
      out_data       <= '0;
      bus.mul_sel    <= 1'b0;
      bus.mul_wrt    <= 1'b0;
      bus.mul_nres   <= 1'b0;
      bus.mul_addr_b <= 1'b0;
    end else begin
      out_err <= 1'b0;
      case (state)
        ST_INIT: begin
          bus.mul_sel  <= 1'b1;
          bus.mul_nres <= 1'b0;
          if (icnt == ICW'(INIT_CYC - 1)) begin
            state        <= ST_IDLE;
            icnt         <= '0;
            bus.mul_sel  <= 1'b0;
            bus.mul_nres <= 1'b1;
            in_ready     <= 1'b1;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (in_valid) begin
            a_q            <= in_a;
            b_q            <= in_b;
            in_ready       <= 1'b0;
            state          <= ST_WR0;
            bus.mul_sel    <= 1'b1;
            bus.mul_wrt    <= 1'b1;
            bus.mul_addr_b <= 1'b0;
          end
        end

        ST_WR0, ST_WR1, ST_RD: begin
          if (bus.mul_ready) begin
            case (state)
              ST_WR0: begin
                state          <= ST_WR1;
                bus.mul_addr_b <= 1'b1;
              end
              ST_WR1: begin
                state          <= ST_RD;
                bus.mul_wrt    <= 1'b0;
                bus.mul_addr_b <= 1'b0;
              end
              default: begin
                state       <= ST_OUT;
                out_data    <= bus.mul_rdata;
                out_valid   <= 1'b1;
                bus.mul_sel <= 1'b0;
              end
            endcase
          end else if (expired) begin
            // Drop the pair and re-clear the multiplier.
            state          <= ST_INIT;
            icnt           <= '0;
            out_err        <= 1'b1;
            bus.mul_sel    <= 1'b1;
            bus.mul_wrt    <= 1'b0;
            bus.mul_nres   <= 1'b0;
            bus.mul_addr_b <= 1'b0;
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state <= ST_INIT;
          icnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_bus_master.sv
// Self-checking bench for mul_bus_master: a behavioural multiplier on the
// bus plus directed and randomized operand pairs checked against plain
// signed arithmetic.
module tb_mul_bus_master;
  import mul_pkg::*;

  localparam int SZ  = 8;
  localparam int TMO = TMO_DEF;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SZ-1:0] in_a = '0, in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*SZ-2:0] out_data;
  logic          out_err;

  mul_bus_master_if #(.SZin(SZ)) bus ();

  mul_bus_master #(.SZin(SZ), .TMO(TMO), .INIT_CYC(2)) dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural multiplier ----------------
  // rmode: 0 ready always, 1 random ready (at most 5 idle cycles in a row),
  //        2 ready stuck low while operand 1 is written,
  //        3 ready held low in the read phase until its TMO-th cycle.
  int rmode = 0;
  int streak = 0;
  int rd_cyc = 0;
  int err_cnt = 0;
  logic [SZ-1:0] mreg [2];
  logic signed [2*SZ-1:0] prod;

  always @(posedge clk) begin
    if (!bus.mul_nres) begin
      mreg[0] <= '0;
      mreg[1] <= '0;
    end else if (bus.mul_sel && bus.mul_wrt && bus.mul_ready) begin
      mreg[bus.mul_addr_b] <= bus.mul_wdata;
    end
  end

  assign prod          = $signed(mreg[0]) * $signed(mreg[1]);
  assign bus.mul_rdata = prod[2*SZ-2:0];

  always @(negedge clk) begin
    case (rmode)
      0: bus.mul_ready <= 1'b1;
      1: begin
        if (streak >= 5 || $urandom_range(1, 0) == 1) begin
          bus.mul_ready <= 1'b1;
          streak        <= 0;
        end else begin
          bus.mul_ready <= 1'b0;
          streak        <= streak + 1;
        end
      end
      2: bus.mul_ready <= !(bus.mul_sel && bus.mul_wrt && bus.mul_addr_b);
      default: begin
        if (bus.mul_sel && !bus.mul_wrt && bus.mul_nres) begin
          bus.mul_ready <= (rd_cyc + 1 == TMO);
          rd_cyc        <= rd_cyc + 1;
        end else begin
          bus.mul_ready <= 1'b1;
          rd_cyc        <= 0;
        end
      end
    endcase
  end

  always @(negedge clk) if (out_err) err_cnt <= err_cnt + 1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed product, low 2*SZ-1 bits as delivered.
  function automatic logic [2*SZ-2:0] ref_mul(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[2*SZ-2:0];
  endfunction

  // Present a pair and wait for its acceptance; returns one negedge after
  // the accept negedge with in_valid dropped.
  task automatic offer(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input string tag);
    int k;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                         input int hold, input int exp_lat, input string tag);
    int lat;
    logic [2*SZ-2:0] exp_p;
    exp_p = ref_mul(a, b);
    offer(a, b, tag);
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(out_data), 32'(exp_p));
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(out_data), 32'(exp_p));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_err"}, 32'(out_err), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_mul_sel"}, 32'(bus.mul_sel), 32'd0);
    chk({tag, "_mul_nres"}, 32'(bus.mul_nres), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nlow, wr1, ov, err0;
    logic [SZ-1:0] ra, rb;

    // Reset state and clear sequence
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    nlow = 0; k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      if (!bus.mul_nres) nlow++;
      @(negedge clk); k++;
    end
    chk("init_nres_low_cycles", 32'(nlow), 32'd2);
    chk("init_nres_released", 32'(bus.mul_nres), 32'd1);
    chk("init_in_ready", 32'(in_ready), 32'd1);

    // Basic products with a ready multiplier
    rmode = 0;
    run_txn(8'h02, 8'h05, 0, 4, "pos");
    run_txn(8'hFE, 8'h05, 3, 4, "neg");

    // Stuck ready while writing operand 1: timeout, re-clear, no product
    err0 = err_cnt;
    rmode = 2;
    offer(8'h11, 8'h22, "tmo");
    wr1 = 0; ov = 0; k = 0;
    while (!out_err && k < 100) begin
      if (bus.mul_sel && bus.mul_wrt && bus.mul_addr_b) wr1++;
      if (out_valid) ov = 1;
      @(negedge clk); k++;
    end
    chk("tmo_wr1_cycles", 32'(wr1), 32'(TMO));
    chk("tmo_err_pulse", 32'(out_err), 32'd1);
    chk("tmo_reclear", 32'(bus.mul_nres), 32'd0);
    rmode = 0;
    @(negedge clk);
    chk("tmo_err_one_cycle", 32'(out_err), 32'd0);
    k = 0;
    while (!in_ready && k < 20) begin
      if (out_valid) ov = 1;
      @(negedge clk); k++;
    end
    chk("tmo_no_product", 32'(ov), 32'd0);
    chk("tmo_back_idle", 32'(in_ready), 32'd1);
    chk("tmo_err_count", 32'(err_cnt), 32'(err0 + 1));

    // Read ready arriving in exactly the last allowed cycle
    err0 = err_cnt;
    rmode = 3;
    run_txn(8'h07, 8'hFD, 0, 3 + TMO, "rd_late");
    rmode = 0;
    chk("rd_late_no_err", 32'(err_cnt), 32'(err0));

    // Reset while reading: outputs drop at once, pair is discarded
    offer(8'h33, 8'h44, "rst_mid");
    k = 0;
    while (!(bus.mul_sel && !bus.mul_wrt && bus.mul_nres) && k < 20) begin
      @(negedge clk); k++;
    end
    chk("rst_mid_in_rd", 32'(bus.mul_sel && !bus.mul_wrt), 32'd1);
    res = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    ov = 0; k = 0;
    while (!in_ready && k < 20) begin
      if (out_valid) ov = 1;
      @(negedge clk); k++;
    end
    chk("rst_mid_no_product", 32'(ov), 32'd0);
    run_txn(8'h7F, 8'h81, 1, 4, "after_rst");

    // Randomized pairs with random multiplier stalls and backpressure
    err0 = err_cnt;
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      ra = SZ'($urandom);
      rb = SZ'($urandom);
      run_txn(ra, rb, $urandom_range(2, 0), 0, "rand");
    end
    rmode = 0;
    chk("rand_no_err", 32'(err_cnt), 32'(err0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
